countdown_ctrl: RTL and testbench

Sequencer for the team's down-counter datapath. It owns a synchronous down counter with a prescaler, loads a start value on command, and counts to zero for a programmable number of rounds, reloading between rounds. It reports terminal count and completion to the surrounding control logic. It sits between the top-level control/tester logic and the counter output bus `qOut`.

---
 rtl/countdown_ctrl.sv | 102 ++++++++++
 tb/tb_countdown_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// Down-counter sequencer: prescaled count-to-zero for a number of rounds, with pause/abort.
// Build option STICKY_DONE_EN: done stays high after completion until the next accepted start.
module countdown_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4,
    parameter int ROUNDS_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    load_val,
    input  logic [ROUNDS_W-1:0] rounds,
    input  logic                pause,
    input  logic                abort,
    output logic [WIDTH-1:0]    qOut,
    output logic                busy,
    output logic                tc,
    output logic                done,
    output logic [ROUNDS_W-1:0] round_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    state_t              state;
    logic [PW-1:0]       presc;
    logic [WIDTH-1:0]    load_q;
    logic [ROUNDS_W-1:0] rounds_q;
    logic                tick;
    logic [ROUNDS_W-1:0] next_round;

    assign tick       = (presc == PW'(PRESCALE - 1));
    assign next_round = round_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            presc     <= '0;
            load_q    <= '0;
            rounds_q  <= '0;
            qOut      <= '0;
            busy      <= 1'b0;
            tc        <= 1'b0;
            done      <= 1'b0;
            round_cnt <= '0;
        end else begin
            tc <= 1'b0;
`ifndef STICKY_DONE_EN
            done <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        qOut      <= load_val;
                        presc     <= '0;
                        round_cnt <= '0;
                        load_q    <= load_val;
                        rounds_q  <= (rounds == '0) ? ROUNDS_W'(1) : rounds;
`ifdef STICKY_DONE_EN
                        done      <= 1'b0;
`endif
                    end
                end
                RUN, HOLD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        qOut  <= '0;
                    end else if (pause) begin
                        // prescaler and counter freeze; a pending tick is deferred, not dropped
                        state <= HOLD;
                    end else begin
                        state <= RUN;
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            if (qOut != '0) begin
                                qOut <= qOut - 1'b1;
                            end else begin
                                tc        <= 1'b1;
                                round_cnt <= next_round;
                                if (next_round == rounds_q) begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    qOut  <= '0;
                                end else begin
                                    qOut <= load_q;
                                end
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Vector-table bench for countdown_ctrl; each row drives inputs for n cycles and checks outputs after each edge.
module tb_countdown_ctrl;

    localparam int WIDTH    = 4;
    localparam int PRESCALE = 4;
    localparam int ROUNDS_W = 3;

`ifdef STICKY_DONE_EN
    localparam logic S = 1'b1;
`else
    localparam logic S = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst, start, pause, abort;
    logic [WIDTH-1:0]    load_val;
    logic [ROUNDS_W-1:0] rounds;
    logic [WIDTH-1:0]    qOut;
    logic                busy, tc, done;
    logic [ROUNDS_W-1:0] round_cnt;

    countdown_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESCALE), .ROUNDS_W(ROUNDS_W)) dut (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val), .rounds(rounds),
        .pause(pause), .abort(abort), .qOut(qOut), .busy(busy), .tc(tc), .done(done),
        .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0]    q;
        logic                busy;
        logic                tc;
        logic                done;
        logic [ROUNDS_W-1:0] rc;
    } exp_t;

    typedef struct {
        logic                rst;
        logic                start;
        logic [WIDTH-1:0]    lv;
        logic [ROUNDS_W-1:0] rd;
        logic                pause;
        logic                abort;
        int                  n;
        exp_t                e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic r, input logic s, input int lv, input int rd,
                       input logic p, input logic a, input int n,
                       input int q, input logic b, input logic t, input logic d, input int rc);
        vec_t v;
        v.rst = r; v.start = s; v.lv = WIDTH'(lv); v.rd = ROUNDS_W'(rd);
        v.pause = p; v.abort = a; v.n = n;
        v.e.q = WIDTH'(q); v.e.busy = b; v.e.tc = t; v.e.done = d; v.e.rc = ROUNDS_W'(rc);
        vecs.push_back(v);
    endtask

    task automatic check(input int row);
        exp_t e, act;
        e   = sb.pop_front();
        act = '{q: qOut, busy: busy, tc: tc, done: done, rc: round_cnt};
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL row%0d: got q=%0d busy=%b tc=%b done=%b rc=%0d, want q=%0d busy=%b tc=%b done=%b rc=%0d",
                     row, act.q, act.busy, act.tc, act.done, act.rc, e.q, e.busy, e.tc, e.done, e.rc);
        end
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    int cyc, ntc;

    initial begin
        rst = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; load_val = '0; rounds = '0;

        // 1. reset held with start asserted
        add(0,1,5,1,0,0, 2,  0,0,0,0,0);
        add(1,0,0,0,0,0, 1,  0,0,0,0,0);
        // 2. single pass from 3; start at edge 3 and in DONE ignored
        add(1,1,3,1,0,0, 1,  3,1,0,0,0);
        add(1,0,0,0,0,0, 2,  3,1,0,0,0);
        add(1,1,9,5,0,0, 1,  3,1,0,0,0);
        add(1,0,0,0,0,0, 4,  2,1,0,0,0);
        add(1,0,0,0,0,0, 4,  1,1,0,0,0);
        add(1,0,0,0,0,0, 4,  0,1,0,0,0);
        add(1,0,0,0,0,0, 1,  0,0,1,1,1);
        add(1,1,9,5,0,0, 1,  0,0,0,S,1);
        add(1,0,0,0,0,0, 2,  0,0,0,S,1);
        // 3. two rounds from 1
        add(1,1,1,2,0,0, 1,  1,1,0,0,0);
        add(1,0,0,0,0,0, 3,  1,1,0,0,0);
        add(1,0,0,0,0,0, 4,  0,1,0,0,0);
        add(1,0,0,0,0,0, 1,  1,1,1,0,1);
        add(1,0,0,0,0,0, 3,  1,1,0,0,1);
        add(1,0,0,0,0,0, 4,  0,1,0,0,1);
        add(1,0,0,0,0,0, 1,  0,0,1,1,2);
        add(1,0,0,0,0,0, 1,  0,0,0,S,2);
        // 4. pause sampled at edges 6..11 delays terminal to edge 22
        add(1,1,3,1,0,0, 1,  3,1,0,0,0);
        add(1,0,0,0,0,0, 3,  3,1,0,0,0);
        add(1,0,0,0,0,0, 2,  2,1,0,0,0);
        add(1,0,0,0,1,0, 6,  2,1,0,0,0);
        add(1,0,0,0,0,0, 2,  2,1,0,0,0);
        add(1,0,0,0,0,0, 4,  1,1,0,0,0);
        add(1,0,0,0,0,0, 4,  0,1,0,0,0);
        add(1,0,0,0,0,0, 1,  0,0,1,1,1);
        add(1,0,0,0,0,0, 1,  0,0,0,S,1);
        // 5. abort at edge 7, then start+abort in IDLE ignored
        add(1,1,5,3,0,0, 1,  5,1,0,0,0);
        add(1,0,0,0,0,0, 3,  5,1,0,0,0);
        add(1,0,0,0,0,0, 3,  4,1,0,0,0);
        add(1,0,0,0,0,1, 1,  0,0,0,0,0);
        add(1,0,0,0,0,0, 3,  0,0,0,0,0);
        add(1,1,7,1,0,1, 1,  0,0,0,0,0);
        add(1,0,0,0,0,0, 2,  0,0,0,0,0);
        // abort after one completed round keeps round_cnt
        add(1,1,0,3,0,0, 1,  0,1,0,0,0);
        add(1,0,0,0,0,0, 3,  0,1,0,0,0);
        add(1,0,0,0,0,0, 1,  0,1,1,0,1);
        add(1,0,0,0,0,1, 1,  0,0,0,0,1);
        add(1,0,0,0,0,0, 2,  0,0,0,0,1);
        // abort wins over pause while in HOLD
        add(1,1,2,1,0,0, 2,  2,1,0,0,0);
        add(1,0,0,0,1,0, 2,  2,1,0,0,0);
        add(1,0,0,0,1,1, 1,  0,0,0,0,0);
        add(1,0,0,0,0,0, 1,  0,0,0,0,0);
        // 6. load 0 / rounds 0 -> terminal and done at edge 4
        add(1,1,0,0,0,0, 1,  0,1,0,0,0);
        add(1,0,0,0,0,0, 3,  0,1,0,0,0);
        add(1,0,0,0,0,0, 1,  0,0,1,1,1);
        add(1,0,0,0,0,0, 1,  0,0,0,S,1);
        // reset sampled at edge 10 of a run
        add(1,1,7,2,0,0, 1,  7,1,0,0,0);
        add(1,0,0,0,0,0, 3,  7,1,0,0,0);
        add(1,0,0,0,0,0, 4,  6,1,0,0,0);
        add(1,0,0,0,0,0, 2,  5,1,0,0,0);
        add(0,1,3,1,0,0, 1,  0,0,0,0,0);
        add(1,0,0,0,0,0, 2,  0,0,0,0,0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                rst = vecs[i].rst; start = vecs[i].start; load_val = vecs[i].lv;
                rounds = vecs[i].rd; pause = vecs[i].pause; abort = vecs[i].abort;
                sb.push_back(vecs[i].e);
                @(posedge clk); #1;
                check(i);
            end
        end

        // three rounds from 2: done expected (2+1)*4*3 = 36 edges after accept
        rst = 1'b1; start = 1'b1; load_val = 4'd2; rounds = 3'd3; pause = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; ntc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (tc) ntc++;
        end
        expect_int("rounds3_done_cycle", cyc, 36);
        expect_int("rounds3_tc_count", ntc, 3);
        expect_int("rounds3_round_cnt", int'(round_cnt), 3);
        expect_int("rounds3_busy_at_done", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
